matrix_vec_mac_seq: RTL and testbench
=====================================

# matrix_vec_mac_seq

Parametrised, time-multiplexed signed fixed-point matrix-vector multiplier computing y = A·x for a ROWS×COLS matrix. It replaces the fully combinational 32×10 layer multiplier in the NN datapath with ROWS parallel MAC lanes stepping one column per cycle. It adds a valid/ready handshake, signed arithmetic, and per-row saturation or wrap with overflow flags. It sits between the weight/activation buffers and the activation-function stage of each dense layer.

## Interface
- ROWS, 32, output rows / MAC lanes
- COLS, 10, input vector length = accumulation steps
- W, 32, word width, two's complement
- FRAC, 24, fractional bits (Q(W-FRAC).FRAC); 0 ≤ FRAC < W
- SAT, 1, 1 = saturate results to W bits, 0 = wrap to low W bits

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  A and x valid
- in_ready  out  1  block idle, accepts a transaction
- A  in  ROWS*COLS*W  matrix; row 0 in MSBs, column 0 in MSBs within each row
- x  in  COLS*W  vector; element 0 in MSBs
- out_valid  out  1  y and ovf valid
- out_ready  in  1  consumer accepts y
- y  out  ROWS*W  result; row 0 in MSBs
- ovf  out  ROWS  per-row overflow flag; bit r belongs to row r

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register A and x, clear all accumulators, set col=0, go to RUN. A and x are ignored after the acceptance edge.
- RUN: each edge, for every row r: prod = signed A[r][col] × signed x[col] (2W bits); term = prod[FRAC+W-1:FRAC], i.e. per-product truncation via arithmetic shift; acc[r] += term.
- acc width is W+ceil(log2(COLS)) guard bits, so there is no intermediate overflow.
- col increments each edge. At the edge that consumes col==COLS-1, go to DONE.
- DONE: out_valid=1. y[r] = sat/wrap(acc[r]), combinational from the registered accumulators, stable for all of DONE.
  - SAT=1: clamp to [-2^(W-1), 2^(W-1)-1]; ovf[r]=1 iff clamped.
  - SAT=0: low W bits; ovf[r]=1 iff the discarded guard bits are not a sign extension.
- On out_valid&&out_ready, go to IDLE. y and ovf keep their values until the next acceptance clears the accumulators.
- There is no overlap: in_ready=0 in RUN and DONE. in_valid outside IDLE is ignored, not queued.
- There is no abort input. Only rst_n cancels a transaction.

## Timing
- Reset values (rst_n low, asynchronous):
  - state=IDLE, col=0, acc=0
  - out_valid=0, y=0, ovf=0
  - in_ready=0; in_ready is registered and rises at the first clk edge after rst_n deasserts.
- Latency: acceptance edge T0. Columns 0..COLS-1 accumulate on edges T1..T_COLS. out_valid is high from T_COLS until the consumer handshake.
- Min transaction period: COLS+2 cycles (acceptance, COLS RUN cycles, DONE handshake, return to IDLE).
- With out_ready held high in DONE, out_valid stays high for exactly one cycle.
- Reset mid-RUN or mid-DONE: out_valid drops immediately and the partial result is discarded. The next transaction after reset is unaffected.
- COLS=1: a single RUN cycle. The col counter width is max(1, ceil(log2 COLS)).

## Test plan
- Reset: hold rst_n low with in_valid=1. Required: in_ready=0, out_valid=0, y=0, ovf=0. After release, in_ready=1 at the first edge and the transaction is accepted on the following edge.
- Identity (defaults): A[r][c]=0x01000000 (1.0) when c==r mod 10, else 0; x[c]=(c+1)·2^24. Required: y[r]=((r mod 10)+1)·2^24, ovf=0, out_valid exactly 10 edges after acceptance.
- Signed/truncation: all A=0xFF800000 (-0.5), all x=0x03000000 (3.0). Required: every y=0xF1000000 (-15.0), ovf=0.
  - Also: A[r][0]=1 LSB, x[0]=1 LSB, all others 0. Required: y=0, since the product truncates away.
- Overflow: all A=0x64000000 (100.0), all x=0x01000000 (1.0). Required: SAT=1 gives y=0x7FFFFFFF and ovf all ones; SAT=0 gives y=0xE8000000 and ovf all ones.
- Backpressure: hold out_ready low for 5 cycles in DONE and pulse in_valid meanwhile. Required: y, ovf and out_valid are stable, in_ready=0, the pulse is ignored. After the handshake, IDLE on the next edge and the new transaction gives correct results.
- Mid-run reset: assert rst_n at col=4, release, then run the identity test. Required: out_valid never rises for the aborted job, and the identity results are correct.

Source files
------------

// File: rtl/matrix_vec_mac_seq.sv
// Time-multiplexed signed fixed-point matrix-vector multiplier, y = A*x.
// ROWS parallel MAC lanes step through one column per cycle with a valid/ready handshake.
module matrix_vec_mac_seq #(
   parameter int unsigned ROWS = 32,
   parameter int unsigned COLS = 10,
   parameter int unsigned W    = 32,
   parameter int unsigned FRAC = 24,
   parameter int unsigned SAT  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ROWS*COLS*W-1:0]  A,
   input  logic [COLS*W-1:0]       x,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ROWS*W-1:0]       y,
   output logic [ROWS-1:0]         ovf
);

   // Guard bits let COLS full-scale terms sum without intermediate overflow.
   localparam int unsigned AW = W + $clog2(COLS);
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [CW-1:0] LastCol = CW'(COLS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e              state_q, state_d;
   logic                in_ready_q;
   logic [CW-1:0]       col_q;
   logic                accept, step;

   logic signed [W-1:0]  a_q   [ROWS][COLS];
   logic signed [W-1:0]  x_q   [COLS];
   logic signed [AW-1:0] acc_q [ROWS];
   logic signed [AW-1:0] term  [ROWS];
   logic signed [W-1:0]  x_cur;

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == StDone);
   assign x_cur     = x_q[col_q];

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid && in_ready_q) begin
               accept  = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            step = 1'b1;
            if (col_q == LastCol) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         in_ready_q <= 1'b0;
         col_q      <= '0;
         for (int r = 0; r < ROWS; r++) begin
            acc_q[r] <= '0;
         end
      end else begin
         state_q    <= state_d;
         // Registered ready: low for the first cycle out of reset.
         in_ready_q <= (state_d == StIdle);
         if (accept) begin
            col_q <= '0;
            for (int r = 0; r < ROWS; r++) begin
               acc_q[r] <= '0;
            end
         end else if (step) begin
            col_q <= col_q + 1'b1;
            for (int r = 0; r < ROWS; r++) begin
               acc_q[r] <= acc_q[r] + term[r];
            end
         end
      end
   end

   // Operand capture; contents only matter after an acceptance, so no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               a_q[r][c] <= A[(ROWS*COLS-1-(r*COLS+c))*W +: W];
            end
         end
         for (int c = 0; c < COLS; c++) begin
            x_q[c] <= x[(COLS-1-c)*W +: W];
         end
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      logic signed [W-1:0]   a_cur;
      logic signed [2*W-1:0] prod;
      logic signed [W-1:0]   term_w;
      logic [AW-W:0]         top;
      logic                  over;

      assign a_cur  = a_q[r][col_q];
      assign prod   = a_cur * x_cur;
      // Arithmetic shift then truncate: floors each product to FRAC bits.
      assign term_w = W'(prod >>> FRAC);
      assign term[r] = AW'($signed(term_w));

      // Fits in W bits iff the guard bits and the W-bit sign bit all agree.
      assign top  = acc_q[r][AW-1:W-1];
      assign over = ~((&top) | ~(|top));

      assign ovf[r] = over;
      assign y[(ROWS-1-r)*W +: W] =
         ((SAT != 0) && over) ? (acc_q[r][AW-1] ? {1'b1, {(W-1){1'b0}}}
                                                : {1'b0, {(W-1){1'b1}}})
                              : acc_q[r][W-1:0];
   end

endmodule

// File: tb/tb_matrix_vec_mac_seq.sv
// Self-checking bench: saturating and wrapping instances driven in lockstep, checked
// against directed vectors and a plain-arithmetic reference model.
module tb_matrix_vec_mac_seq;

   localparam int unsigned ROWS = 32;
   localparam int unsigned COLS = 10;
   localparam int unsigned W    = 32;
   localparam int unsigned FRAC = 24;

   logic                   clk;
   logic                   rst_n;
   logic                   in_valid;
   logic                   out_ready;
   logic [ROWS*COLS*W-1:0] a_flat;
   logic [COLS*W-1:0]      x_flat;
   logic                   in_ready_s, in_ready_w;
   logic                   out_valid_s, out_valid_w;
   logic [ROWS*W-1:0]      y_s, y_w;
   logic [ROWS-1:0]        ovf_s, ovf_w;

   int checks;
   int errors;
   int a_m [ROWS][COLS];
   int x_m [COLS];

   typedef struct {
      logic [31:0] a;
      logic [31:0] xv;
      logic [31:0] ysat;
      logic        osat;
      logic [31:0] ywrap;
   } vec_t;

   vec_t vecs [6];

   matrix_vec_mac_seq #(.ROWS(ROWS), .COLS(COLS), .W(W), .FRAC(FRAC), .SAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
      .A(a_flat), .x(x_flat), .out_valid(out_valid_s), .out_ready(out_ready),
      .y(y_s), .ovf(ovf_s)
   );

   matrix_vec_mac_seq #(.ROWS(ROWS), .COLS(COLS), .W(W), .FRAC(FRAC), .SAT(0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
      .A(a_flat), .x(x_flat), .out_valid(out_valid_w), .out_ready(out_ready),
      .y(y_w), .ovf(ovf_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pack();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            a_flat[(ROWS*COLS-1-(r*COLS+c))*W +: W] = a_m[r][c];
      for (int c = 0; c < COLS; c++)
         x_flat[(COLS-1-c)*W +: W] = x_m[c];
   endtask

   task automatic set_uniform(input logic [31:0] a, input logic [31:0] xv);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            a_m[r][c] = a;
      for (int c = 0; c < COLS; c++)
         x_m[c] = xv;
   endtask

   task automatic set_identity();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            a_m[r][c] = (c == (r % COLS)) ? 32'h0100_0000 : 0;
      for (int c = 0; c < COLS; c++)
         x_m[c] = (c + 1) << FRAC;
   endtask

   // y = A*x from plain integer arithmetic: floor each product, sum, then clamp or wrap.
   task automatic model(output logic [ROWS*W-1:0] ys, output logic [ROWS-1:0] os,
                        output logic [ROWS*W-1:0] yw, output logic [ROWS-1:0] ow);
      for (int r = 0; r < ROWS; r++) begin
         logic signed [63:0] s;
         logic               o;
         s = 0;
         for (int c = 0; c < COLS; c++) begin
            longint p;
            int     t;
            p = longint'(a_m[r][c]) * longint'(x_m[c]);
            t = int'(p >>> FRAC);
            s = s + longint'(t);
         end
         o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         ys[(ROWS-1-r)*W +: W] = o ? (s < 0 ? 32'h8000_0000 : 32'h7FFF_FFFF) : s[W-1:0];
         yw[(ROWS-1-r)*W +: W] = s[W-1:0];
         os[r] = o;
         ow[r] = o;
      end
   endtask

   task automatic start_txn();
      int n;
      n = 0;
      while (!in_ready_s && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", {63'd0, in_ready_s}, 64'd1);
      pack();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      // Scramble the inputs: they must be ignored after acceptance.
      for (int i = 0; i < ROWS*COLS; i++) a_flat[i*W +: W] = $urandom;
      for (int i = 0; i < COLS; i++) x_flat[i*W +: W] = $urandom;
   endtask

   task automatic finish_txn(input int hold);
      int                lat;
      logic [ROWS*W-1:0] ys, yw, y_hold;
      logic [ROWS-1:0]   os, ow, o_hold;
      lat = 0;
      while (!out_valid_s && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, COLS);
      check("out_valid_wrap", {63'd0, out_valid_w}, 64'd1);
      model(ys, os, yw, ow);
      for (int r = 0; r < ROWS; r++) begin
         check($sformatf("y_sat[%0d]", r), y_s[(ROWS-1-r)*W +: W], ys[(ROWS-1-r)*W +: W]);
         check($sformatf("y_wrap[%0d]", r), y_w[(ROWS-1-r)*W +: W], yw[(ROWS-1-r)*W +: W]);
      end
      check("ovf_sat", ovf_s, os);
      check("ovf_wrap", ovf_w, ow);
      y_hold = y_s;
      o_hold = ovf_s;
      for (int i = 0; i < hold; i++) begin
         in_valid = (i == 2);
         @(negedge clk);
         check("bp_out_valid", {63'd0, out_valid_s}, 64'd1);
         check("bp_in_ready", {63'd0, in_ready_s}, 64'd0);
         check("bp_y_row0", y_s[ROWS*W-1 -: W], y_hold[ROWS*W-1 -: W]);
         check("bp_y_rowlast", y_s[W-1:0], y_hold[W-1:0]);
         check("bp_ovf", ovf_s, o_hold);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_one_cycle", {63'd0, out_valid_s}, 64'd0);
      check("idle_in_ready", {63'd0, in_ready_s}, 64'd1);
   endtask

   initial begin
      logic seen;
      checks    = 0;
      errors    = 0;
      a_flat    = '0;
      x_flat    = '0;
      out_ready = 1'b0;

      vecs[0] = '{a: 32'hFF80_0000, xv: 32'h0300_0000, ysat: 32'hF100_0000, osat: 1'b0,
                  ywrap: 32'hF100_0000};
      vecs[1] = '{a: 32'h6400_0000, xv: 32'h0100_0000, ysat: 32'h7FFF_FFFF, osat: 1'b1,
                  ywrap: 32'hE800_0000};
      vecs[2] = '{a: 32'h9C00_0000, xv: 32'h0100_0000, ysat: 32'h8000_0000, osat: 1'b1,
                  ywrap: 32'h1800_0000};
      vecs[3] = '{a: 32'h0100_0000, xv: 32'h0100_0000, ysat: 32'h0A00_0000, osat: 1'b0,
                  ywrap: 32'h0A00_0000};
      vecs[4] = '{a: 32'h0000_0001, xv: 32'h0000_0001, ysat: 32'h0000_0000, osat: 1'b0,
                  ywrap: 32'h0000_0000};
      vecs[5] = '{a: 32'hFFFF_FFFF, xv: 32'h0000_0001, ysat: 32'hFFFF_FFF6, osat: 1'b0,
                  ywrap: 32'hFFFF_FFF6};

      // Reset with in_valid held high, then identity accepted on the second edge.
      set_identity();
      pack();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      #12;
      check("rst_in_ready", {63'd0, in_ready_s}, 64'd0);
      check("rst_out_valid", {62'd0, out_valid_s, out_valid_w}, 64'd0);
      check("rst_y_sat", {32'd0, y_s[ROWS*W-1 -: W]}, 64'd0);
      check("rst_y_wrap", {32'd0, y_w[W-1:0]}, 64'd0);
      check("rst_ovf", {ovf_s, ovf_w}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_first_edge_ready", {63'd0, in_ready_s}, 64'd1);
      @(negedge clk);
      check("rst_accepted", {63'd0, in_ready_s}, 64'd0);
      in_valid = 1'b0;
      finish_txn(0);
      for (int r = 0; r < ROWS; r++)
         check($sformatf("ident_y[%0d]", r), y_s[(ROWS-1-r)*W +: W], ((r % COLS) + 1) << FRAC);
      check("ident_ovf", ovf_s, 64'd0);

      for (int i = 0; i < 6; i++) begin
         set_uniform(vecs[i].a, vecs[i].xv);
         start_txn();
         finish_txn(0);
         for (int r = 0; r < ROWS; r += 7) begin
            check($sformatf("vec%0d_ysat[%0d]", i, r), y_s[(ROWS-1-r)*W +: W], vecs[i].ysat);
            check($sformatf("vec%0d_ywrap[%0d]", i, r), y_w[(ROWS-1-r)*W +: W],
                  vecs[i].ywrap);
         end
         check($sformatf("vec%0d_ovf_sat", i), ovf_s, {ROWS{vecs[i].osat}});
         check($sformatf("vec%0d_ovf_wrap", i), ovf_w, {ROWS{vecs[i].osat}});
      end

      // Single-LSB product in column 0 only truncates to zero.
      set_uniform(0, 0);
      for (int r = 0; r < ROWS; r++) a_m[r][0] = 1;
      x_m[0] = 1;
      start_txn();
      finish_txn(0);
      check("lsb_y_row0", y_s[ROWS*W-1 -: W], 64'd0);

      // Backpressure with an ignored in_valid pulse, then a fresh transaction.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) a_m[r][c] = $urandom_range(0, 1 << 26) - (1 << 25);
      for (int c = 0; c < COLS; c++) x_m[c] = $urandom_range(0, 1 << 26) - (1 << 25);
      start_txn();
      finish_txn(5);
      set_identity();
      start_txn();
      finish_txn(0);

      // Reset at col=4: the aborted job must never raise out_valid.
      set_uniform(32'h6400_0000, 32'h0100_0000);
      start_txn();
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {63'd0, out_valid_s}, 64'd0);
      check("midrst_y", y_s[ROWS*W-1 -: W], 64'd0);
      seen = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         seen = seen | out_valid_s | out_valid_w;
      end
      check("midrst_no_out_valid", {63'd0, seen}, 64'd0);
      set_identity();
      start_txn();
      finish_txn(0);
      for (int r = 0; r < ROWS; r++)
         check($sformatf("post_rst_ident[%0d]", r), y_s[(ROWS-1-r)*W +: W],
               ((r % COLS) + 1) << FRAC);

      // Randomized: alternate full-range and small-magnitude operands.
      for (int t = 0; t < 20; t++) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               a_m[r][c] = (t % 2 == 0) ? int'($urandom)
                                        : $urandom_range(0, 1 << 28) - (1 << 27);
         for (int c = 0; c < COLS; c++)
            x_m[c] = (t % 2 == 0) ? int'($urandom) : $urandom_range(0, 1 << 26) - (1 << 25);
         start_txn();
         finish_txn((t % 5 == 0) ? 3 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
